// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry packet buffer between the TCM return path and decode.
// Flush beats push and pop so a redirect always leaves the buffer empty.
module fetch_skid_fifo
   import if_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  fetch_pkt_t push_data,
   input  logic       pop,
   input  logic       flush,
   output logic [1:0] count,
   output fetch_pkt_t head
);

   fetch_pkt_t mem_q [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] count_q, count_d;
   logic       pop_ok;
   logic       push_ok;

   assign pop_ok  = pop && (count_q != 2'd0);
   assign push_ok = push && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push_ok) wr_ptr_d = ~wr_ptr_q;
         if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_ok) mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   // Issue accounting upstream must make a push into a full buffer impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push_ok && (count_q == 2'd2)));

endmodule

// File: rtl/if_fetch.sv
// Fetch stage: PC register, TCM address issue, in-flight tracking, and a
// two-entry buffer presenting {pc, instr} packets to decode.
module if_fetch
   import if_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_pc,
   output logic [DATA_WIDTH-1:0] out_instr
);

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   logic        inflight_q, inflight_d;
   logic [1:0]  count;
   logic [2:0]  occupancy;
   logic        pop;
   logic        issue;
   logic        push;
   fetch_pkt_t  push_data;
   fetch_pkt_t  head;

   assign pop = out_valid && out_ready;

   // Slots already claimed once this cycle's pop leaves; pop implies count>=1.
   assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue     = !redirect_valid && (occupancy < 3'd2);

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_d    = 1'b0;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      end else if (issue) begin
         fetch_pc_d    = fetch_pc_q + 32'd4;
         inflight_pc_d = fetch_pc_q;
         inflight_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         inflight_pc_q <= 32'd0;
         inflight_q    <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         inflight_q    <= inflight_d;
      end
   end

   assign imem_addr = fetch_pc_q[ADDR_WIDTH+1:2];

   assign push            = inflight_q && !redirect_valid;
   assign push_data.pc    = inflight_pc_q;
   assign push_data.instr = INSTR_W'(imem_rdata);

   fetch_skid_fifo u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (redirect_valid),
      .count     (count),
      .head      (head)
   );

   assign out_valid = (count != 2'd0);
   assign out_pc    = head.pc;
   assign out_instr = DATA_WIDTH'(head.instr);

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction TCM and directly downstream of the PC-redirect source (branch/jump resolution).
- Drives the TCM word address.
- Captures the TCM's 1-cycle-latency synchronous read data.
- Presents {pc, instr} packets to decode over a valid/ready handshake, with a 2-entry buffer so decode stalls never lose a fetched word.

Parameters:
- DATA_WIDTH, 32, instruction width; must match the TCM.
- ADDR_WIDTH, 10, TCM word-address width (1024 words).
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  load a new PC; flushes all fetched and in-flight words.
- redirect_pc  in  32  new byte PC; bits [1:0] ignored (forced to 0).
- imem_addr  out  ADDR_WIDTH  TCM word address = fetch_pc[ADDR_WIDTH+1:2].
- imem_rdata  in  DATA_WIDTH  TCM read data, valid the cycle after the address was issued.
- out_valid  out  1  packet available to decode.
- out_ready  in  1  decode accepts; transfer occurs when out_valid && out_ready.
- out_pc  out  32  byte PC of the presented instruction.
- out_instr  out  DATA_WIDTH  instruction word.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; inflight=0; FIFO count=0.
  - out_valid=0; out_pc=0; out_instr=0; imem_addr=RESET_PC[ADDR_WIDTH+1:2].
- imem_addr is always driven from registered fetch_pc; there is no combinational path from redirect_pc.
- pop = out_valid && out_ready.
- Issue rule: issue = !redirect_valid && (count + inflight - pop) < 2.
  - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
  - Otherwise: inflight<=0 and fetch_pc holds.
- Capture: when inflight=1 and !redirect_valid, {inflight_pc, imem_rdata} is written into the FIFO tail at the clock edge ending that cycle.
- Issue accounting guarantees the FIFO never overflows. A write while count==2 is an assertion error.
- Output: out_valid = (count!=0); out_pc and out_instr come from the FIFO head. Head and out_* stay stable while out_valid && !out_ready.
- Latency:
  - First packet after reset release: out_valid=1 in the 3rd cycle (cycle0 issue, cycle1 data, cycle2 presented).
  - Redirect at cycle t: fetch_pc=redirect_pc at t+1, data at t+2, out_valid with the redirect target at t+3.
- Throughput: 1 instr/cycle while out_ready=1. Steady state is count=1, inflight=1.
- Redirect (highest priority):
  - FIFO is cleared (count<=0) and the in-flight word is discarded.
  - No issue in cycle t; out_valid=0 in cycle t+1.
  - A pop coincident with redirect still counts as accepted by decode, but flush wins for FIFO state.
- Wrap-around:
  - fetch_pc wraps modulo 2^32.
  - imem_addr wraps modulo 2^ADDR_WIDTH (aliasing is allowed; no fault generated).
- Stall of any length: at most 2 buffered packets plus 0 in flight. Issue resumes in the same cycle pop is seen.
- rst_n asserted mid-operation: all state cleared immediately. Behaviour after release is identical to power-up.
- This block never writes the TCM; the TCM write port belongs to the loader.

Decomposition:
- Package if_pkg:
  - INSTR_W=32
  - RESET_PC_DEFAULT
  - typedef struct packed {logic [31:0] pc; logic [INSTR_W-1:0] instr;} fetch_pkt_t
- Sub-module fetch_skid_fifo: 2-entry fetch_pkt_t FIFO.
  - Ports: push, push_data, pop, flush, count, head.
  - Async active-low reset; flush has priority over push and pop.
- if_fetch holds the PC, issue logic and in-flight tracking.

Test Plan:
- Reset, TCM preloaded mem[k]=32'hA000_0000+k, out_ready=1 -> out_valid first at cycle 2; then pc 0,4,8,... with instr A0000000,A0000001,... one per cycle, no gaps.
- out_ready=0 for 5 cycles after the first packet -> out_valid held, out_pc=0 stable; on release pcs 0,4,8,C delivered back-to-back with none lost or duplicated.
- redirect_valid with redirect_pc=32'h0000_0103 while 2 packets are buffered -> out_valid=0 next cycle; 3 cycles later out_pc=32'h100, instr=mem[64]; stale pcs never appear.
- Redirect in the same cycle as a pop and a returning in-flight word -> flushed word absent; next packet is the redirect target.
- redirect_pc=32'h0000_0FFC with ADDR_WIDTH=10 -> out_pc 0xFFC (mem[1023]), then 0x1000 with instr=mem[0] (address wrap).
- rst_n pulsed low mid-stream for 1 cycle -> out_valid=0 asynchronously; after release the sequence restarts at RESET_PC with 2-cycle latency.
